// File: rtl/seq_shifter.sv
// Bit-serial shift unit: SLL/SRL/SRA one bit position per clock behind a start/busy/done handshake.
// Produces the same results as the single-cycle combinational shifter.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0]     MODE_SLL = 2'b00;
  localparam logic [1:0]     MODE_SRL = 2'b01;
  localparam logic [1:0]     MODE_SRA = 2'b10;
  localparam logic [1:0]     MODE_RSV = 2'b11;
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [SHW-1:0]   cnt_q;
  logic [SHW-1:0]   cnt_d;
  logic [1:0]       mreg_q;
  logic [WIDTH-1:0] y_q;
  logic             busy_q;
  logic             done_q;

  // One-bit step of the latched operation; the reserved mode never shifts
  // because it is loaded with a zero count.
  always_comb begin
    sreg_d = sreg_q;
    case (mreg_q)
      MODE_SLL: sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      MODE_SRL: sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
      MODE_SRA: sreg_d = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
      default:  sreg_d = sreg_q;
    endcase
  end

  assign cnt_d = cnt_q - CNT_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      mreg_q  <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mreg_q  <= mode;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
            if (mode == MODE_RSV) begin
              sreg_q <= '0;
              cnt_q  <= '0;
            end else begin
              sreg_q <= a;
              cnt_q  <= shamt;
            end
          end
        end
        ST_SHIFT: begin
          if (cnt_q != '0) begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
          end else begin
            y_q     <= sreg_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Randomized self-checking bench for seq_shifter against an arithmetic shift model.
module tb_seq_shifter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [31:0] y;

  int checks;
  int errors;
  logic [31:0] last_y;

  seq_shifter #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .shamt (shamt),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] av, input int sh, input logic [1:0] md);
    case (md)
      2'b00:   return av << sh;
      2'b01:   return av >> sh;
      2'b10:   return $unsigned($signed(av) >>> sh);
      default: return 32'h0;
    endcase
  endfunction

  // Issues one operation from a negedge and follows it to the negedge after done.
  task automatic run_op(input logic [31:0] av, input logic [4:0] sh, input logic [1:0] md,
                        input bit hold, input bit disturb);
    int cycles;
    int busy_cnt;
    int exp_cycles;
    bit got_done;
    logic [31:0] exp_y;
    exp_y      = model(av, int'(sh), md);
    exp_cycles = (md == 2'b11) ? 2 : int'(sh) + 2;
    a = av; shamt = sh; mode = md; start = 1'b1;
    cycles = 0; busy_cnt = 0; got_done = 0;
    while (!got_done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (!hold) start = 1'b0;
      if (disturb) begin
        a = $urandom; shamt = 5'($urandom); mode = 2'($urandom); start = 1'($urandom);
      end
      check("busy_done_excl", {31'b0, busy & done}, 32'h0);
      if (done) got_done = 1;
      else begin
        if (busy) busy_cnt++;
        check("y_hold", y, last_y);
      end
    end
    if (!hold) start = 1'b0;
    check("done_seen", {31'b0, got_done}, 32'h1);
    check("latency", cycles, exp_cycles);
    check("busy_cycles", busy_cnt, exp_cycles - 1);
    check("result", y, exp_y);
    $display("op a=%h shamt=%0d mode=%0d y=%h exp=%h cycles=%0d", av, sh, md, y, exp_y, cycles);
    last_y = exp_y;
    @(negedge clk);
    check("done_pulse", {31'b0, done}, 32'h0);
    check("idle_busy", {31'b0, busy}, 32'h0);
  endtask

  initial begin
    int dones;
    checks = 0; errors = 0; last_y = 32'h0;
    reset = 1'b1; start = 1'b0; a = '0; shamt = '0; mode = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_y", y, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(32'h0000_0001, 5'd4,  2'b00, 0, 0);
    run_op(32'h8000_00F0, 5'd4,  2'b01, 0, 0);
    run_op(32'h8000_00F0, 5'd4,  2'b10, 0, 0);
    run_op(32'hDEAD_BEEF, 5'd0,  2'b10, 0, 0);
    run_op(32'h8000_0000, 5'd31, 2'b10, 0, 0);
    run_op(32'h8000_0000, 5'd31, 2'b01, 0, 0);
    run_op(32'h1234_5678, 5'd9,  2'b11, 0, 0);
    run_op(32'hC001_D00D, 5'd7,  2'b10, 0, 1);

    // Start held high across DONE: next op begins on the edge after the idle cycle
    run_op(32'h0F0F_0F0F, 5'd3, 2'b00, 1, 0);
    run_op(32'hF000_0001, 5'd5, 2'b10, 1, 0);
    start = 1'b0;

    // Asynchronous reset mid-operation
    a = 32'h0000_0001; shamt = 5'd20; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    check("midrst_y", y, 32'h0);
    last_y = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no_done_after_rst", dones, 0);
    run_op(32'h0000_0001, 5'd20, 2'b00, 0, 0);

    // Randomized operations, some with operand/start disturbance during SHIFT
    for (int i = 0; i < 40; i++) begin
      run_op($urandom, 5'($urandom), 2'($urandom), 0, bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
